// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the UART TX report arbiter and its siblings.
package tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_ABORT = 2'd2
  } arb_state_e;

  localparam logic [7:0] TERM_BYTE_DEFAULT = 8'h0A;

  localparam int unsigned REQ_CLOCK = 0;
  localparam int unsigned REQ_ECHO  = 1;
  localparam int unsigned REQ_DHT   = 2;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!gnt_any && req[IW'((32'(ptr) + k) % N)]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'((32'(ptr) + k) % N);
        gnt_oh  = N'(1) << ((32'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/tx_report_arbiter.sv
// Whole-frame round-robin arbiter sharing the UART TX FIFO write port.
// Define TX_ARB_PRIO0_EN to give requester 0 strict priority at arbitration.
module tx_report_arbiter
  import tx_arb_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH  = 8,
  parameter int unsigned            N_REQ       = 3,
  parameter int unsigned            MAX_FRAME   = 16,
  parameter int unsigned            TIMEOUT_CYC = 1000,
  parameter logic [DATA_WIDTH-1:0]  TERM_BYTE   = DATA_WIDTH'(TERM_BYTE_DEFAULT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_last,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_we,
  output logic [DATA_WIDTH-1:0]       fifo_wdata,
  output logic [N_REQ-1:0]            grant,
  output logic                        busy,
  output logic [7:0]                  abort_cnt
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BW = $clog2(MAX_FRAME + 1);
  localparam int unsigned SW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [BW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [7:0]      abort_cnt_q, abort_cnt_d;

  logic [N_REQ-1:0] pick_req, rr_oh, pick_oh;
  logic [IW-1:0]    rr_idx, pick_idx, ptr_nxt;
  logic             rr_any, pick_any;
  logic             g_valid, g_last;
  logic [DATA_WIDTH-1:0] g_data;

`ifdef TX_ARB_PRIO0_EN
  assign pick_req = req_valid & ~N_REQ'(1);
`else
  assign pick_req = req_valid;
`endif

  rr_pick #(.N(N_REQ)) u_pick (
    .req     (pick_req),
    .ptr     (ptr_q),
    .gnt_oh  (rr_oh),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // Final arbitration choice; requester 0 overrides the rotation when prioritised.
  always_comb begin
    pick_oh  = rr_oh;
    pick_idx = rr_idx;
    pick_any = rr_any;
`ifdef TX_ARB_PRIO0_EN
    if (req_valid[0]) begin
      pick_oh  = N_REQ'(1);
      pick_idx = '0;
      pick_any = 1'b1;
    end
`endif
  end

  assign g_valid = req_valid[gidx_q];
  assign g_last  = req_last[gidx_q];
  assign g_data  = req_data[32'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign ptr_nxt = (32'(gidx_q) == N_REQ - 1) ? '0 : gidx_q + IW'(1);

  // Next-state, counters and the combinational FIFO-side strobes.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gidx_d      = gidx_q;
    grant_d     = grant_q;
    byte_cnt_d  = byte_cnt_q;
    stall_cnt_d = stall_cnt_q;
    abort_cnt_d = abort_cnt_q;
    req_ready   = '0;
    fifo_we     = 1'b0;
    fifo_wdata  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d     = pick_oh;
          gidx_d      = pick_idx;
          byte_cnt_d  = '0;
          stall_cnt_d = '0;
          state_d     = ST_XFER;
        end
      end
      ST_XFER: begin
        req_ready  = grant_q & {N_REQ{!fifo_full}};
        fifo_we    = g_valid & !fifo_full;
        fifo_wdata = g_data;
        if (g_valid && !fifo_full) begin
          byte_cnt_d  = byte_cnt_q + BW'(1);
          stall_cnt_d = '0;
          if (g_last) begin
            ptr_d   = ptr_nxt;
            grant_d = '0;
            state_d = ST_IDLE;
          end else if (byte_cnt_q + BW'(1) == BW'(MAX_FRAME)) begin
            state_d = ST_ABORT;
          end
        end else if (!fifo_full) begin
          stall_cnt_d = stall_cnt_q + SW'(1);
          if (stall_cnt_q + SW'(1) == SW'(TIMEOUT_CYC)) begin
            state_d = ST_ABORT;
          end
        end
      end
      ST_ABORT: begin
        if (!fifo_full) begin
          fifo_we     = 1'b1;
          fifo_wdata  = TERM_BYTE;
          abort_cnt_d = (abort_cnt_q == 8'hFF) ? abort_cnt_q : abort_cnt_q + 8'd1;
          ptr_d       = ptr_nxt;
          grant_d     = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gidx_q      <= '0;
      grant_q     <= '0;
      byte_cnt_q  <= '0;
      stall_cnt_q <= '0;
      abort_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gidx_q      <= gidx_d;
      grant_q     <= grant_d;
      byte_cnt_q  <= byte_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      abort_cnt_q <= abort_cnt_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);
  assign abort_cnt = abort_cnt_q;

endmodule
